// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side port bundle between the async FIFO and its UART drain stage.
// read_en pops one byte, fifo_data is valid the following cycle, mem_empty gates popping.
interface fifo_uart_tx_if;
    logic       read_en;
    logic       mem_empty;
    logic [7:0] fifo_data;

    modport master (output read_en, input mem_empty, input fifo_data);
    modport slave  (input read_en, output mem_empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the async FIFO read side and sends them as UART frames, LSB first (8N1; 8E1 with FIFO_UART_PARITY_EN).
// Latency: start bit falls 2 read_clk cycles after the read_en pulse; frame is 10 (11 with parity) * CLKS_PER_BIT cycles.
// Backpressure: pops only in IDLE or on the last STOP cycle with tx_en=1 and FIFO non-empty; one pop per frame.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           read_clk,
    input  logic           reset,
    input  logic           tx_en,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef FIFO_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic          baud_end;
    logic          tx_n;
`ifdef FIFO_UART_PARITY_EN
    logic          parity_q, parity_n;
`endif

    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            tx           <= 1'b1;
            fifo.read_en <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            baud_cnt     <= baud_n;
            bit_cnt      <= bit_n;
            shift        <= shift_n;
            tx           <= tx_n;
            fifo.read_en <= (state_n == S_REQ);
            busy         <= (state_n != S_IDLE);
        end
    end

`ifdef FIFO_UART_PARITY_EN
    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) parity_q <= 1'b0;
        else        parity_q <= parity_n;
    end
`endif

    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift;
        baud_end = (baud_cnt == BAUD_MAX);
`ifdef FIFO_UART_PARITY_EN
        parity_n = parity_q;
`endif
        unique case (state)
            S_IDLE: begin
                if (tx_en && !fifo.mem_empty) state_n = S_REQ;
            end
            S_REQ: begin
                state_n = S_LOAD;
            end
            S_LOAD: begin
                shift_n = fifo.fifo_data;
`ifdef FIFO_UART_PARITY_EN
                parity_n = ^fifo.fifo_data;
`endif
                state_n = S_START;
            end
            S_START: begin
                baud_n = baud_end ? '0 : baud_cnt + CW'(1);
                if (baud_end) state_n = S_DATA;
            end
            S_DATA: begin
                baud_n = baud_end ? '0 : baud_cnt + CW'(1);
                if (baud_end) begin
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef FIFO_UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_PARITY_EN
            S_PARITY: begin
                baud_n = baud_end ? '0 : baud_cnt + CW'(1);
                if (baud_end) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                baud_n = baud_end ? '0 : baud_cnt + CW'(1);
                // Back-to-back frames go straight to REQ, leaving REQ+LOAD as the idle-high gap.
                if (baud_end) state_n = (tx_en && !fifo.mem_empty) ? S_REQ : S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so tx is registered and aligned with state.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
`ifdef FIFO_UART_PARITY_EN
            S_PARITY: tx_n = parity_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a one-cycle-latency FIFO model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FR   = CPB * NB + 2;
    localparam int SPAN = 2 * FR + 16;

    logic read_clk = 1'b0;
    logic reset;
    logic tx_en;
    logic tx;
    logic busy;

    fifo_uart_tx_if fif();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .read_clk (read_clk),
        .reset    (reset),
        .tx_en    (tx_en),
        .fifo     (fif),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 read_clk = ~read_clk;

    logic [7:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int consec_cnt = 0;
    int empty_rd_cnt = 0;
    logic prev_re = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;

    logic tx_s   [0:SPAN-1];
    logic re_s   [0:SPAN-1];
    logic busy_s [0:SPAN-1];

    assign fif.mem_empty = (wr_ptr == rd_ptr);

    always @(posedge read_clk) begin
        if (fif.read_en) begin
            fif.fifo_data <= mem[rd_ptr[3:0]];
            rd_ptr        <= rd_ptr + 1;
            pop_cnt       <= pop_cnt + 1;
        end
    end

    always @(negedge read_clk) begin
        if (fif.read_en && prev_re) consec_cnt++;
        if (fif.read_en && fif.mem_empty) empty_rd_cnt++;
        prev_re = fif.read_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge read_clk);
            if (fif.read_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Sample k=0 is the current negedge (the REQ cycle); optionally drop tx_en after sample drop_k.
    task automatic record(input int n, input int drop_k);
        for (int k = 0; k < n; k++) begin
            tx_s[k]   = tx;
            re_s[k]   = fif.read_en;
            busy_s[k] = busy;
            if (k == drop_k) tx_en = 1'b0;
            if (k < n - 1) @(negedge read_clk);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef FIFO_UART_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic [10:0] frame_exp(input logic [7:0] b);
        logic [10:0] f;
        f = '0;
        for (int i = 0; i < NB; i++) f[i] = exp_bit(b, i);
        return f;
    endfunction

    // Bit i of the frame, or X if the line was not stable for all CPB cycles of that bit.
    function automatic logic [10:0] frame_obs(input int base);
        logic [10:0] f;
        logic v;
        f = '0;
        for (int i = 0; i < NB; i++) begin
            v = tx_s[base + 2 + CPB * i];
            for (int j = 1; j < CPB; j++)
                if (tx_s[base + 2 + CPB * i + j] !== v) v = 1'bx;
            f[i] = v;
        end
        return f;
    endfunction

    function automatic int count_re(input int n);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) if (re_s[k] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        push(8'hA5);
        tx_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge read_clk);
            n_cmp++;
            if ({tx, fif.read_en, busy} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_hold: cycle %0d tx/read_en/busy=%b want 100", c, {tx, fif.read_en, busy});
            end
        end
        n_cmp++;
        if (pop_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_no_pop: pops=%0d want 0", pop_cnt);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        int p0;
        p0 = pop_cnt;
        reset = 1'b1;
        wait_req(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_req: no read_en seen, got 0 want 1");
            return;
        end
        record(FR + 4, -1);
        n_cmp++;
        if ({tx_s[1], tx_s[2]} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_start_edge: tx@+1,+2=%b want 10", {tx_s[1], tx_s[2]});
        end
        n_cmp++;
        if (frame_obs(0) !== frame_exp(8'hA5)) begin
            n_fail++;
            $display("FAIL single_frame: got %b want %b", frame_obs(0), frame_exp(8'hA5));
        end
        n_cmp++;
        if ({busy_s[0], busy_s[FR-1], busy_s[FR]} !== 3'b110) begin
            n_fail++;
            $display("FAIL single_busy: req/laststop/after=%b want 110", {busy_s[0], busy_s[FR-1], busy_s[FR]});
        end
        n_cmp++;
        if ({tx_s[FR], tx_s[FR+1], tx_s[FR+2], tx_s[FR+3]} !== 4'b1111) begin
            n_fail++;
            $display("FAIL single_idle_high: got %b want 1111", {tx_s[FR], tx_s[FR+1], tx_s[FR+2], tx_s[FR+3]});
        end
        n_cmp++;
        if (count_re(FR + 4) !== 1 || pop_cnt - p0 !== 1) begin
            n_fail++;
            $display("FAIL single_pops: pulses=%0d pops=%0d want 1 1", count_re(FR + 4), pop_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int p0;
        p0 = pop_cnt;
        push(8'h00);
        push(8'hFF);
        wait_req(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_req: no read_en seen, got 0 want 1");
            return;
        end
        record(2 * FR + 4, -1);
        n_cmp++;
        if (frame_obs(0) !== frame_exp(8'h00)) begin
            n_fail++;
            $display("FAIL b2b_frame0: got %b want %b", frame_obs(0), frame_exp(8'h00));
        end
        n_cmp++;
        if (frame_obs(FR) !== frame_exp(8'hFF)) begin
            n_fail++;
            $display("FAIL b2b_frame1: got %b want %b", frame_obs(FR), frame_exp(8'hFF));
        end
        n_cmp++;
        if ({re_s[FR], tx_s[FR], tx_s[FR+1], tx_s[FR+2], busy_s[FR]} !== 5'b11101) begin
            n_fail++;
            $display("FAIL b2b_gap: re/tx/tx/tx/busy=%b want 11101",
                     {re_s[FR], tx_s[FR], tx_s[FR+1], tx_s[FR+2], busy_s[FR]});
        end
        n_cmp++;
        if (count_re(2 * FR + 4) !== 2 || pop_cnt - p0 !== 2 || consec_cnt !== 0) begin
            n_fail++;
            $display("FAIL b2b_pops: pulses=%0d pops=%0d consecutive=%0d want 2 2 0",
                     count_re(2 * FR + 4), pop_cnt - p0, consec_cnt);
        end
        n_cmp++;
        if (busy_s[2 * FR] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_end: got %b want 0", busy_s[2 * FR]);
        end
    endtask

    task automatic test_tx_en_stop();
        bit ok;
        bit bad;
        int p0;
        p0 = pop_cnt;
        push(8'h3C);
        push(8'h11);
        wait_req(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL txen_req: no read_en seen, got 0 want 1");
            return;
        end
        record(FR + 12, 10);
        n_cmp++;
        if (frame_obs(0) !== frame_exp(8'h3C)) begin
            n_fail++;
            $display("FAIL txen_frame: got %b want %b", frame_obs(0), frame_exp(8'h3C));
        end
        bad = 1'b0;
        for (int k = FR; k < FR + 12; k++)
            if (tx_s[k] !== 1'b1 || busy_s[k] !== 1'b0 || re_s[k] !== 1'b0) bad = 1'b1;
        n_cmp++;
        if (bad || pop_cnt - p0 !== 1) begin
            n_fail++;
            $display("FAIL txen_hold: unstable=%0d pops=%0d want 0 1", bad, pop_cnt - p0);
        end
        tx_en = 1'b1;
        wait_req(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL txen_resume: no read_en seen, got 0 want 1");
            return;
        end
        record(FR + 4, -1);
        n_cmp++;
        if (frame_obs(0) !== frame_exp(8'h11) || pop_cnt - p0 !== 2) begin
            n_fail++;
            $display("FAIL txen_resume_frame: got %b pops=%0d want %b 2", frame_obs(0), pop_cnt - p0, frame_exp(8'h11));
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int p0;
        p0 = pop_cnt;
        push(8'h55);
        push(8'h81);
        wait_req(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_req: no read_en seen, got 0 want 1");
            return;
        end
        record(2 + 4 * CPB + 1, -1);
        n_cmp++;
        if (tx_s[2 + 4 * CPB] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_bit3_before: tx=%b want 0", tx_s[2 + 4 * CPB]);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({tx, fif.read_en, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_immediate: tx/read_en/busy=%b want 100", {tx, fif.read_en, busy});
        end
        repeat (3) @(negedge read_clk);
        n_cmp++;
        if (pop_cnt - p0 !== 1 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold: pops=%0d tx=%b want 1 1", pop_cnt - p0, tx);
        end
        reset = 1'b1;
        wait_req(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_after_req: no read_en seen, got 0 want 1");
            return;
        end
        record(FR + 4, -1);
        n_cmp++;
        if (frame_obs(0) !== frame_exp(8'h81) || pop_cnt - p0 !== 2 || count_re(FR + 4) !== 1) begin
            n_fail++;
            $display("FAIL rst_after_frame: got %b pops=%0d want %b 2", frame_obs(0), pop_cnt - p0, frame_exp(8'h81));
        end
    endtask

`ifdef FIFO_UART_PARITY_EN
    task automatic test_parity();
        bit ok;
        push(8'hA5);
        push(8'h07);
        wait_req(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL par_req: no read_en seen, got 0 want 1");
            return;
        end
        record(2 * FR + 4, -1);
        n_cmp++;
        if ({tx_s[2 + CPB * 9], tx_s[FR + 2 + CPB * 9]} !== 2'b01) begin
            n_fail++;
            $display("FAIL par_bits: got %b want 01", {tx_s[2 + CPB * 9], tx_s[FR + 2 + CPB * 9]});
        end
        n_cmp++;
        if (frame_obs(0) !== frame_exp(8'hA5) || frame_obs(FR) !== frame_exp(8'h07)) begin
            n_fail++;
            $display("FAIL par_frames: got %b %b want %b %b", frame_obs(0), frame_obs(FR), frame_exp(8'hA5), frame_exp(8'h07));
        end
        n_cmp++;
        if ({re_s[FR], busy_s[2 * FR - 1], busy_s[2 * FR]} !== 3'b110) begin
            n_fail++;
            $display("FAIL par_length: re/busy/busy=%b want 110", {re_s[FR], busy_s[2 * FR - 1], busy_s[2 * FR]});
        end
    endtask
`endif

    task automatic test_protocol();
        n_cmp++;
        if (consec_cnt !== 0 || empty_rd_cnt !== 0) begin
            n_fail++;
            $display("FAIL protocol: consecutive=%0d while_empty=%0d want 0 0", consec_cnt, empty_rd_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        tx_en = 1'b0;
        #3;
        reset = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_tx_en_stop();
        test_reset_midframe();
`ifdef FIFO_UART_PARITY_EN
        test_parity();
`endif
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
